stopwatch_ctrl: RTL and testbench

Control sequencer for the 4-digit 00.00–99.99 s stopwatch datapath, which comprises the pulse prescaler, the cascaded 0-9 counters and the BCD-to-7-segment decoders. It debounces two raw push-buttons, runs a start/stop/lap/clear state machine, and gates the 0.01 s tick into the counter chain. It also drives the display-freeze (lap) and counter-clear controls, and latches an overflow flag when the count wraps past 99.99.

---
 rtl/stopwatch_ctrl.sv | 138 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounces the start/stop and lap/reset buttons,
// runs the IDLE/RUN/LAP/STOP machine and gates the 0.01 s tick into the digit counters.
module stopwatch_ctrl #(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lr,
  input  logic       tick_in,
  input  logic       ovf_in,
  output logic       tick_out,
  output logic       run_en,
  output logic       cnt_clr,
  output logic       lap_load,
  output logic       disp_hold,
  output logic       ovf_flag,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } state_t;

  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

  // Bit 0 carries the start/stop button, bit 1 the lap/reset button.
  logic [1:0]       raw;
  logic [1:0]       s1;
  logic [1:0]       s2;
  logic [1:0]       stable;
  logic [1:0]       stable_prev;
  logic [1:0]       press;
  logic [DEB_W-1:0] cnt [2];

  state_t cur;
  state_t nxt;
  logic   ss_press;
  logic   lr_press;
  logic   ovf_accept;
  logic   to_lap;
  logic   to_clear;

  assign raw = {btn_lr, btn_ss};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1          <= '0;
      s2          <= '0;
      stable      <= '0;
      stable_prev <= '0;
      press       <= '0;
      for (int i = 0; i < 2; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1          <= raw;
      s2          <= s1;
      stable_prev <= stable;
      press       <= stable & ~stable_prev;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DEB_MAX) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign ss_press   = press[0];
  assign lr_press   = press[1];
  assign ovf_accept = ovf_in & ((cur == RUN) | (cur == LAP));

  always_ff @(posedge clk) begin
    if (rst) begin
      cur <= IDLE;
    end else begin
      cur <= nxt;
    end
  end

  // Overflow outranks any press, and start/stop outranks lap/reset.
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE: if (ss_press) nxt = RUN;
      RUN: begin
        if (ovf_in)        nxt = STOP;
        else if (ss_press) nxt = STOP;
        else if (lr_press) nxt = LAP;
      end
      LAP: begin
        if (ovf_in)        nxt = STOP;
        else if (ss_press) nxt = STOP;
        else if (lr_press) nxt = RUN;
      end
      STOP: begin
        if (ss_press)      nxt = RUN;
        else if (lr_press) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign to_lap   = (cur == RUN) & (nxt == LAP);
  assign to_clear = (cur == STOP) & (nxt == IDLE);

  // Strobes are registered so they appear in the first cycle of the new state.
  always_ff @(posedge clk) begin
    if (rst) begin
      lap_load <= 1'b0;
      cnt_clr  <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      lap_load <= to_lap;
      cnt_clr  <= to_clear;
      if (ovf_accept) begin
        ovf_flag <= 1'b1;
      end else if (to_clear) begin
        ovf_flag <= 1'b0;
      end
    end
  end

  assign run_en    = (cur == RUN) | (cur == LAP);
  assign disp_hold = (cur == LAP);
  assign tick_out  = tick_in & run_en;
  assign state     = cur;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with a short debounce: directed vector table,
// multi-cycle corner sequences and random button/overflow traffic against an event-level model.
module tb_stopwatch_ctrl;

  localparam int DEB = 4;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_LAP  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_ss;
  logic       btn_lr;
  logic       tick_in;
  logic       ovf_in;
  logic       tick_out;
  logic       run_en;
  logic       cnt_clr;
  logic       lap_load;
  logic       disp_hold;
  logic       ovf_flag;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEB_CYCLES(DEB), .DEB_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_ss    (btn_ss),
    .btn_lr    (btn_lr),
    .tick_in   (tick_in),
    .ovf_in    (ovf_in),
    .tick_out  (tick_out),
    .run_en    (run_en),
    .cnt_clr   (cnt_clr),
    .lap_load  (lap_load),
    .disp_hold (disp_hold),
    .ovf_flag  (ovf_flag),
    .state     (state)
  );

  // Event-level model: next state looked up per accepted event.
  logic [1:0] ss_next [4] = '{S_RUN, S_STOP, S_STOP, S_RUN};
  logic [1:0] lr_next [4] = '{S_IDLE, S_LAP, S_RUN, S_IDLE};
  logic [1:0] m_state;
  logic       m_ovf;
  logic       m_lap;
  logic       m_clr;

  // Values seen in the cycle a transition lands, for the vector table.
  logic [1:0] tr_state;
  logic       tr_run, tr_hold, tr_ovf, tr_lap, tr_clr;
  logic [1:0] ob_state;
  logic       ob_run, ob_hold, ob_ovf, ob_lap, ob_clr;

  typedef struct {
    logic       ss;
    logic       lr;
    logic       ovf;
    logic [1:0] st;
    logic       run;
    logic       hold;
    logic       ovf_f;
    logic       lap;
    logic       clr;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic ss, input logic lr, input logic ovf,
                              input logic [1:0] st, input logic run, input logic hold,
                              input logic ovf_f, input logic lap, input logic clr);
    vec_t v;
    v.ss = ss; v.lr = lr; v.ovf = ovf; v.st = st; v.run = run;
    v.hold = hold; v.ovf_f = ovf_f; v.lap = lap; v.clr = clr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = S_IDLE;
    m_ovf   = 1'b0;
    m_lap   = 1'b0;
    m_clr   = 1'b0;
  endtask

  task automatic model_event(input logic ss, input logic lr, input logic ovf);
    logic [1:0] prev;
    prev = m_state;
    if (ovf && (m_state == S_RUN || m_state == S_LAP)) begin
      m_state = S_STOP;
      m_ovf   = 1'b1;
    end else if (ss) begin
      m_state = ss_next[m_state];
    end else if (lr) begin
      m_state = lr_next[m_state];
    end
    m_lap = (prev == S_RUN) && (m_state == S_LAP);
    m_clr = (prev == S_STOP) && (m_state == S_IDLE);
    if (m_clr) m_ovf = 1'b0;
  endtask

  // One clock: drive a random tick after the edge, then check every output.
  task automatic idle_cycle();
    logic exp_run;
    @(posedge clk);
    #2;
    ovf_in  = 1'b0;
    tick_in = 1'($urandom_range(0, 1));
    #1;
    exp_run = (m_state == S_RUN) || (m_state == S_LAP);
    chk("state", 32'(state), 32'(m_state));
    chk("run_en", 32'(run_en), 32'(exp_run));
    chk("disp_hold", 32'(disp_hold), 32'(m_state == S_LAP));
    chk("ovf_flag", 32'(ovf_flag), 32'(m_ovf));
    chk("lap_load", 32'(lap_load), 32'(m_lap));
    chk("cnt_clr", 32'(cnt_clr), 32'(m_clr));
    chk("tick_out", 32'(tick_out), 32'(tick_in & exp_run));
    ob_state = state; ob_run = run_en; ob_hold = disp_hold;
    ob_ovf = ovf_flag; ob_lap = lap_load; ob_clr = cnt_clr;
    m_lap = 1'b0;
    m_clr = 1'b0;
  endtask

  task automatic capture();
    tr_state = ob_state; tr_run = ob_run; tr_hold = ob_hold;
    tr_ovf = ob_ovf; tr_lap = ob_lap; tr_clr = ob_clr;
  endtask

  // Buttons are already high and first sampled at the next edge.
  task automatic press_core(input logic ss, input logic lr, input logic ovf);
    repeat (DEB + 3) idle_cycle();
    if (ovf) ovf_in = 1'b1;
    model_event(ss, lr, ovf);
    idle_cycle();
    capture();
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (DEB + 5) idle_cycle();
  endtask

  task automatic do_press(input logic ss, input logic lr, input logic ovf);
    btn_ss = ss;
    btn_lr = lr;
    press_core(ss, lr, ovf);
  endtask

  task automatic do_ovf();
    idle_cycle();
    ovf_in = 1'b1;
    model_event(1'b0, 1'b0, 1'b1);
    idle_cycle();
    capture();
    repeat (2) idle_cycle();
  endtask

  task automatic do_reset(input logic held_ss);
    rst    = 1'b1;
    btn_ss = held_ss;
    btn_lr = 1'b0;
    model_reset();
    idle_cycle();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(0, 1, 0, S_IDLE, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, S_RUN,  1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 0, S_LAP,  1, 1, 0, 1, 0);
    vecs[3]  = mk(0, 1, 0, S_RUN,  1, 0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 0, S_STOP, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 1, 0, S_IDLE, 0, 0, 0, 0, 1);
    vecs[6]  = mk(1, 0, 0, S_RUN,  1, 0, 0, 0, 0);
    vecs[7]  = mk(1, 0, 1, S_STOP, 0, 0, 1, 0, 0);
    vecs[8]  = mk(1, 0, 0, S_RUN,  1, 0, 1, 0, 0);
    vecs[9]  = mk(1, 0, 0, S_STOP, 0, 0, 1, 0, 0);
    vecs[10] = mk(0, 1, 0, S_IDLE, 0, 0, 0, 0, 1);
    vecs[11] = mk(1, 1, 0, S_RUN,  1, 0, 0, 0, 0);
    vecs[12] = mk(0, 1, 0, S_LAP,  1, 1, 0, 1, 0);
    vecs[13] = mk(0, 0, 1, S_STOP, 0, 0, 1, 0, 0);
    vecs[14] = mk(0, 0, 1, S_STOP, 0, 0, 1, 0, 0);
    vecs[15] = mk(0, 1, 0, S_IDLE, 0, 0, 0, 0, 1);

    rst = 1'b1; btn_ss = 1'b0; btn_lr = 1'b0; tick_in = 1'b0; ovf_in = 1'b0;
    model_reset();
    repeat (3) idle_cycle();
    rst = 1'b0;
    chk("reset_state", 32'(state), 32'(S_IDLE));

    // Three-cycle blip is one short of the debounce window: no press.
    btn_ss = 1'b1;
    repeat (3) idle_cycle();
    btn_ss = 1'b0;
    repeat (DEB + 6) idle_cycle();
    chk("blip_idle", 32'(state), 32'(S_IDLE));

    // Held press with a two-cycle dropout yields exactly one press.
    btn_ss = 1'b1;
    repeat (2) idle_cycle();
    btn_ss = 1'b0;
    repeat (2) idle_cycle();
    do_press(1'b1, 1'b0, 1'b0);
    chk("dropout_run", 32'(tr_state), 32'(S_RUN));

    do_reset(1'b0);
    repeat (2) idle_cycle();

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].ss || vecs[i].lr) do_press(vecs[i].ss, vecs[i].lr, vecs[i].ovf);
      else do_ovf();
      chk($sformatf("vec%0d_state", i), 32'(tr_state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_run", i), 32'(tr_run), 32'(vecs[i].run));
      chk($sformatf("vec%0d_hold", i), 32'(tr_hold), 32'(vecs[i].hold));
      chk($sformatf("vec%0d_ovf", i), 32'(tr_ovf), 32'(vecs[i].ovf_f));
      chk($sformatf("vec%0d_lap", i), 32'(tr_lap), 32'(vecs[i].lap));
      chk($sformatf("vec%0d_clr", i), 32'(tr_clr), 32'(vecs[i].clr));
    end

    // Reset while in LAP returns everything to zero on the same edge.
    do_press(1'b1, 1'b0, 1'b0);
    do_press(1'b0, 1'b1, 1'b0);
    chk("lap_hold", 32'(disp_hold), 32'd1);
    do_reset(1'b0);
    chk("rst_state", 32'(state), 32'(S_IDLE));
    chk("rst_outs", 32'({run_en, cnt_clr, lap_load, disp_hold, ovf_flag}), 32'd0);

    // A button held through reset still produces one press afterwards.
    do_reset(1'b1);
    press_core(1'b1, 1'b0, 1'b0);
    chk("held_rst_run", 32'(tr_state), 32'(S_RUN));

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: do_press(1'b1, 1'b0, 1'b0);
        1: do_press(1'b0, 1'b1, 1'b0);
        2: do_press(1'b1, 1'b1, 1'b0);
        3: do_ovf();
        4: do_press(1'b1, 1'b0, 1'b1);
        default: repeat ($urandom_range(1, 6)) idle_cycle();
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
